dot_product_arbiter: RTL and testbench

- Shares one combinational `dot_product` datapath (two 3-vectors of IEEE-754 doubles, packed {x,y,z} high-to-low in 192 bits, 64-bit double result) between NUM_REQ ray-tracer requesters, such as the shading, reflection and intersection units.
- Arbitration is round-robin, with valid/ready on both the request and response sides.
- Results are tagged with the requester id and returned in issue order through an output FIFO.
- Credit-based issue control means no result is ever dropped under response backpressure.

---
 rtl/dot_product_arbiter_pkg.sv | 21 ++
 rtl/dot_product.sv | 18 +
 rtl/dot_product_arbiter_rr_arbiter.sv | 35 +++
 rtl/dot_product_arbiter.sv | 151 +++++++++++++++
 tb/tb_dot_product_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_product_arbiter_pkg.sv
// rtl/dot_product_arbiter_pkg.sv - shared ray-tracer vector/float widths, component slices and clog2
package dot_product_arbiter_pkg;

    localparam int VEC_W = 192;
    localparam int FLT_W = 64;

    localparam int X_HI = 191;
    localparam int X_LO = 128;
    localparam int Y_HI = 127;
    localparam int Y_LO = 64;
    localparam int Z_HI = 63;
    localparam int Z_LO = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dot_product.sv
// rtl/dot_product.sv - combinational double-precision 3-vector dot product
// Summation order is ((x*x) + (y*y)) + (z*z); results depend on that order bit-for-bit.
module dot_product
    import dot_product_arbiter_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    input  logic [VEC_W-1:0] vec_n,
    output logic [FLT_W-1:0] dot
);

    always_comb begin
        dot = $realtobits(
            ($bitstoreal(vec_i[X_HI:X_LO]) * $bitstoreal(vec_n[X_HI:X_LO])
           + $bitstoreal(vec_i[Y_HI:Y_LO]) * $bitstoreal(vec_n[Y_HI:Y_LO]))
           + $bitstoreal(vec_i[Z_HI:Z_LO]) * $bitstoreal(vec_n[Z_HI:Z_LO]));
    end

endmodule

// File: rtl/dot_product_arbiter_rr_arbiter.sv
// rtl/dot_product_arbiter_rr_arbiter.sv - round-robin search from a pointer, one-hot grant plus encoded winner
module rr_arbiter
    import dot_product_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] ptr,
    input  logic                      en,
    output logic [NUM_REQ-1:0]        grant,
    output logic [clog2(NUM_REQ)-1:0] winner,
    output logic                      found
);

    localparam int IW = clog2(NUM_REQ);

    logic [IW-1:0] idx;

    // winner is reported even when en is low so the caller can see contention
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = IW'((int'(ptr) + o) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (found && en) grant[winner] = 1'b1;
    end

endmodule

// File: rtl/dot_product_arbiter.sv
// rtl/dot_product_arbiter.sv - round-robin shared dot-product datapath with credit-controlled response FIFO
module dot_product_arbiter
    import dot_product_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DP_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*VEC_W-1:0]    req_i,
    input  logic [NUM_REQ*VEC_W-1:0]    req_n,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [FLT_W-1:0]            rsp_dot,
    output logic [clog2(FIFO_DEPTH):0]  in_flight
);

    localparam int IW = clog2(NUM_REQ);
    localparam int PW = clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    winner;
    logic             found;
    logic             issue_ok;
    logic             accept;
    logic             pop;

    logic [VEC_W-1:0] op_i;
    logic [VEC_W-1:0] op_n;
    logic [IW-1:0]    op_tag;
    logic             op_valid;
    logic [FLT_W-1:0] dp_dot;

    logic             wr_valid;
    logic [FLT_W-1:0] wr_dot;
    logic [IW-1:0]    wr_tag;

    logic [FLT_W-1:0] mem_dot [FIFO_DEPTH];
    logic [IW-1:0]    mem_tag [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // credits come from registered in_flight only, so a pop never frees a slot in the same cycle
    assign issue_ok = (in_flight < CW'(FIFO_DEPTH));
    assign accept   = found && issue_ok && rst_n;
    assign pop      = rsp_valid && rsp_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (issue_ok && rst_n),
        .grant  (req_ready),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            op_i     <= '0;
            op_n     <= '0;
            op_tag   <= '0;
            op_valid <= 1'b0;
        end else begin
            op_valid <= accept;
            if (accept) begin
                ptr    <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                op_i   <= req_i[winner*VEC_W +: VEC_W];
                op_n   <= req_n[winner*VEC_W +: VEC_W];
                op_tag <= winner;
            end
        end
    end

    dot_product u_dp (
        .vec_i (op_i),
        .vec_n (op_n),
        .dot   (dp_dot)
    );

    generate
        if (DP_LATENCY == 1) begin : g_direct
            assign wr_valid = op_valid;
            assign wr_dot   = dp_dot;
            assign wr_tag   = op_tag;
        end else begin : g_pipe
            logic [FLT_W-1:0]      p_dot [DP_LATENCY-1];
            logic [IW-1:0]         p_tag [DP_LATENCY-1];
            logic [DP_LATENCY-2:0] p_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_vld <= '0;
                    for (int s = 0; s < DP_LATENCY - 1; s++) begin
                        p_dot[s] <= '0;
                        p_tag[s] <= '0;
                    end
                end else begin
                    p_vld[0] <= op_valid;
                    p_dot[0] <= dp_dot;
                    p_tag[0] <= op_tag;
                    for (int s = 1; s < DP_LATENCY - 1; s++) begin
                        p_vld[s] <= p_vld[s-1];
                        p_dot[s] <= p_dot[s-1];
                        p_tag[s] <= p_tag[s-1];
                    end
                end
            end

            assign wr_valid = p_vld[DP_LATENCY-2];
            assign wr_dot   = p_dot[DP_LATENCY-2];
            assign wr_tag   = p_tag[DP_LATENCY-2];
        end
    endgenerate

    // show-ahead FIFO; credits guarantee a write always finds a free slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_flight <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_dot[e] <= '0;
                mem_tag[e] <= '0;
            end
        end else begin
            if (wr_valid) begin
                mem_dot[wr_ptr] <= wr_dot;
                mem_tag[wr_ptr] <= wr_tag;
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count     <= count + CW'(wr_valid) - CW'(pop);
            in_flight <= in_flight + CW'(accept) - CW'(pop);
        end
    end

    assign rsp_valid = (count != '0);
    assign rsp_id    = mem_tag[rd_ptr];
    assign rsp_dot   = mem_dot[rd_ptr];

endmodule

// File: tb/tb_dot_product_arbiter.sv
// tb/tb_dot_product_arbiter.sv - scenario tasks against a queue-based reference of arbiter, credits and FIFO
module tb_dot_product_arbiter;

    localparam int NR = 4;
    localparam int DP = 1;
    localparam int FD = 4;
    localparam int VW = 192;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*VW-1:0]  req_i;
    logic [NR*VW-1:0]  req_n;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [63:0]       rsp_dot;
    logic [2:0]        in_flight;

    int n_checks;
    int n_fail;

    typedef struct {
        int          id;
        logic [63:0] dot;
        int          due;
    } ent_t;

    ent_t m_pipe[$];
    ent_t m_fifo[$];
    int   m_ptr;
    int   m_cred;
    int   cyc;

    dot_product_arbiter #(.NUM_REQ(NR), .DP_LATENCY(DP), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_i     (req_i),
        .req_n     (req_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dot   (rsp_dot),
        .in_flight (in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_dot(input logic [191:0] a, input logic [191:0] b);
        real s;
        s = $bitstoreal(a[191:128]) * $bitstoreal(b[191:128]);
        s = s + $bitstoreal(a[127:64]) * $bitstoreal(b[127:64]);
        s = s + $bitstoreal(a[63:0]) * $bitstoreal(b[63:0]);
        return $realtobits(s);
    endfunction

    function automatic int ref_winner();
        for (int o = 0; o < NR; o++) begin
            if (req_valid[(m_ptr + o) % NR]) return (m_ptr + o) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] ref_ready();
        logic [NR-1:0] one;
        int w;
        one = 1;
        w = ref_winner();
        if (w < 0 || m_cred >= FD) return '0;
        return one << w;
    endfunction

    function automatic logic [63:0] rnd_d();
        return $realtobits(real'(int'($urandom_range(0, 4000)) - 2000) / 16.0);
    endfunction

    task automatic set_ops(input int k, input logic [191:0] a, input logic [191:0] b);
        req_i[k*VW +: VW] = a;
        req_n[k*VW +: VW] = b;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NR; k++) set_ops(k, {rnd_d(), rnd_d(), rnd_d()}, {rnd_d(), rnd_d(), rnd_d()});
    endtask

    task automatic model_reset();
        m_pipe.delete();
        m_fifo.delete();
        m_ptr  = 0;
        m_cred = 0;
    endtask

    // one clock: predict this edge from current inputs, advance, settle 1 ns past the edge
    task automatic tick();
        int   w;
        bit   acc;
        bit   pp;
        ent_t e;
        w   = ref_winner();
        acc = (w >= 0) && (m_cred < FD) && (rst_n == 1'b1);
        pp  = (m_fifo.size() > 0) && (rsp_ready == 1'b1);
        e.id = 0; e.dot = '0; e.due = 0;
        if (acc) begin
            e.id  = w;
            e.dot = ref_dot(req_i[w*VW +: VW], req_n[w*VW +: VW]);
        end
        @(posedge clk);
        cyc++;
        if (pp) void'(m_fifo.pop_front());
        while (m_pipe.size() > 0 && m_pipe[0].due <= cyc) m_fifo.push_back(m_pipe.pop_front());
        if (acc) begin
            e.due = cyc + DP;
            m_pipe.push_back(e);
            m_ptr = (w + 1) % NR;
        end
        m_cred += int'(acc) - int'(pp);
        #1;
    endtask

    task automatic drain();
        int guard;
        req_valid = '0;
        rsp_ready = 1'b1;
        guard = 0;
        while (m_cred > 0 && guard < 50) begin
            tick();
            guard++;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (in_flight !== 3'd0 || m_cred != 0) begin
            n_fail++;
            $display("FAIL drain in_flight got %0d want 0 (model %0d)", in_flight, m_cred);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        rand_ops();
        #1;
        n_checks += 5;
        if (req_ready !== '0)     begin n_fail++; $display("FAIL reset req_ready got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL reset rsp_valid got %b want 0", rsp_valid); end
        if (rsp_id !== 2'd0)      begin n_fail++; $display("FAIL reset rsp_id got %0d want 0", rsp_id); end
        if (rsp_dot !== 64'd0)    begin n_fail++; $display("FAIL reset rsp_dot got %h want 0", rsp_dot); end
        if (in_flight !== 3'd0)   begin n_fail++; $display("FAIL reset in_flight got %0d want 0", in_flight); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        req_valid = '0;
        model_reset();
        tick();
    endtask

    task automatic test_single();
        logic [191:0] a;
        logic [191:0] b;
        int lat;
        a = {$realtobits(12.54), $realtobits(14.67), $realtobits(-16.0)};
        b = {$realtobits(-3.0), $realtobits(-2.234), $realtobits(1.234)};
        set_ops(2, a, b);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single grant got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_checks += 3;
        if (lat != DP)           begin n_fail++; $display("FAIL single latency got %0d edges want %0d", lat, DP); end
        if (rsp_id !== 2'd2)     begin n_fail++; $display("FAIL single rsp_id got %0d want 2", rsp_id); end
        if (rsp_dot !== ref_dot(a, b)) begin n_fail++; $display("FAIL single rsp_dot got %h want %h", rsp_dot, ref_dot(a, b)); end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || in_flight !== 3'd0) begin
            n_fail++; $display("FAIL single after pop rsp_valid %b in_flight %0d want 0 0", rsp_valid, in_flight);
        end
    endtask

    task automatic test_fairness();
        int accepts;
        int prev;
        accepts = 0;
        prev = -1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rand_ops();
            #1;
            n_checks++;
            if (req_ready !== ref_ready()) begin n_fail++; $display("FAIL fair grant c%0d got %b want %b", c, req_ready, ref_ready()); end
            if (req_ready != '0) begin
                accepts++;
                n_checks++;
                if (prev >= 0 && req_ready !== (4'b0001 << ((prev + 1) % NR))) begin
                    n_fail++; $display("FAIL fair order c%0d got %b after id %0d", c, req_ready, prev);
                end
                for (int k = 0; k < NR; k++) if (req_ready[k]) prev = k;
            end
            if (rsp_valid && m_fifo.size() > 0) begin
                n_checks++;
                if (rsp_id !== 2'(m_fifo[0].id) || rsp_dot !== m_fifo[0].dot) begin
                    n_fail++; $display("FAIL fair rsp c%0d got id %0d dot %h want id %0d dot %h", c, rsp_id, rsp_dot, m_fifo[0].id, m_fifo[0].dot);
                end
            end
            tick();
        end
        n_checks++;
        if (accepts != 16) begin n_fail++; $display("FAIL fair throughput got %0d accepts want 16", accepts); end
        drain();
    endtask

    task automatic test_backpressure();
        int accepts;
        accepts = 0;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        repeat (6) begin
            rand_ops();
            #1;
            if (|(req_valid & req_ready)) accepts++;
            tick();
        end
        n_checks += 3;
        if (accepts != FD)        begin n_fail++; $display("FAIL bp accepts got %0d want %0d", accepts, FD); end
        if (req_ready !== '0)     begin n_fail++; $display("FAIL bp full req_ready got %b want 0", req_ready); end
        if (in_flight !== 3'(FD)) begin n_fail++; $display("FAIL bp in_flight got %0d want %0d", in_flight, FD); end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL bp pop-cycle req_ready got %b want 0", req_ready); end
        tick();
        rsp_ready = 1'b0;
        #1;
        n_checks += 2;
        if (req_ready === '0 || req_ready !== ref_ready()) begin
            n_fail++; $display("FAIL bp reassert req_ready got %b want %b", req_ready, ref_ready());
        end
        if (in_flight !== 3'd3) begin n_fail++; $display("FAIL bp after pop in_flight got %0d want 3", in_flight); end
    endtask

    task automatic test_accept_pop();
        int guard;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        rand_ops();
        #1;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (in_flight !== 3'd3) begin n_fail++; $display("FAIL acc+pop in_flight got %0d want 3", in_flight); end
        rsp_ready = 1'b1;
        guard = 0;
        while (m_cred > 0 && guard < 20) begin
            if (m_fifo.size() > 0) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(m_fifo[0].id) || rsp_dot !== m_fifo[0].dot) begin
                    n_fail++; $display("FAIL acc+pop order got v%b id %0d dot %h want id %0d dot %h", rsp_valid, rsp_id, rsp_dot, m_fifo[0].id, m_fifo[0].dot);
                end
            end
            tick();
            guard++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [191:0] a;
        logic [191:0] b;
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        repeat (3) begin rand_ops(); #1; tick(); end
        req_valid = '0;
        repeat (DP) tick();
        req_valid = 4'b0110;
        #1;
        tick();
        req_valid = '0;
        n_checks++;
        if (in_flight !== 3'd4) begin n_fail++; $display("FAIL mid-reset setup in_flight got %0d want 4", in_flight); end
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin n_fail++; $display("FAIL mid-reset rsp_valid %b req_ready %b want 0", rsp_valid, req_ready); end
        if (in_flight !== 3'd0) begin n_fail++; $display("FAIL mid-reset in_flight got %0d want 0", in_flight); end
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid-reset pointer grant got %b want 0001", req_ready); end
        a = {rnd_d(), rnd_d(), rnd_d()};
        b = {rnd_d(), rnd_d(), rnd_d()};
        set_ops(1, a, b);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid-reset req1 grant got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_dot !== ref_dot(a, b)) begin
            n_fail++; $display("FAIL mid-reset result v%b id %0d dot %h want id 1 dot %h", rsp_valid, rsp_id, rsp_dot, ref_dot(a, b));
        end
        drain();
    endtask

    task automatic special_one(input logic [191:0] a, input logic [191:0] b, output logic [63:0] got);
        int lat;
        set_ops(0, a, b);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        tick();
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        got = rsp_valid ? rsp_dot : 64'd0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_special();
        logic [63:0] got;
        logic [63:0] one;
        logic [63:0] inf;
        one = $realtobits(1.0);
        inf = 64'h7FF0000000000000;
        special_one({64'd0, 64'd0, 64'd0}, {inf, one, one}, got);
        n_checks++;
        if (!(got[62:52] == 11'h7FF && got[51:0] != 52'd0)) begin n_fail++; $display("FAIL special nan got %h want NaN", got); end
        special_one({$realtobits(1.0), $realtobits(2.0), $realtobits(3.0)},
                    {$realtobits(4.0), $realtobits(5.0), $realtobits(6.0)}, got);
        n_checks++;
        if (got !== 64'h4040000000000000) begin n_fail++; $display("FAIL special 32.0 got %h want 4040000000000000", got); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = NR'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            #1;
            n_checks += 3;
            if (req_ready !== ref_ready())            begin n_fail++; $display("FAIL rand grant c%0d got %b want %b", c, req_ready, ref_ready()); end
            if (rsp_valid !== (m_fifo.size() > 0))    begin n_fail++; $display("FAIL rand rsp_valid c%0d got %b want %b", c, rsp_valid, m_fifo.size() > 0); end
            if (in_flight !== 3'(m_cred))             begin n_fail++; $display("FAIL rand in_flight c%0d got %0d want %0d", c, in_flight, m_cred); end
            if (rsp_valid && m_fifo.size() > 0) begin
                n_checks++;
                if (rsp_id !== 2'(m_fifo[0].id) || rsp_dot !== m_fifo[0].dot) begin
                    n_fail++; $display("FAIL rand head c%0d got id %0d dot %h want id %0d dot %h", c, rsp_id, rsp_dot, m_fifo[0].id, m_fifo[0].dot);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_i     = '0;
        req_n     = '0;
        rst_n     = 1'b1;
        model_reset();
        #3;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_accept_pop();
        test_reset_mid();
        test_special();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
